// File: rtl/cpu_defs.sv
// Shared CPU definitions: PC-select encodings used by fetch and the controller,
// fetch FSM states and the default reset vector.
package cpu_defs;

  localparam logic [2:0] SEL_PC_SEQ    = 3'd0;
  localparam logic [2:0] SEL_PC_BRANCH = 3'd1;
  localparam logic [2:0] SEL_PC_JUMP   = 3'd2;
  localparam logic [2:0] SEL_PC_JR     = 3'd3;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } fetch_state_t;

  // Only branch, jump and jr change control flow; other encodings fall through.
  function automatic logic is_redirect_sel(input logic [2:0] sel);
    return (sel == SEL_PC_BRANCH) || (sel == SEL_PC_JUMP) || (sel == SEL_PC_JR);
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational redirect-target calculator for branch, j/jal and jr.
module next_pc_calc
  import cpu_defs::*;
(
  input  logic [2:0]  sel_pc,
  input  logic [31:0] redirect_pc,
  input  logic [15:0] branch_imm,
  input  logic [25:0] jadr,
  input  logic [31:0] jr_target,
  output logic [31:0] target,
  output logic        misalign
);

  logic [31:0] link;

  assign link = redirect_pc + 32'd4;

  // NOTE: every output gets a default before the case, so no path leaves it unassigned (no latch).
  always_comb begin
    target   = link;
    misalign = 1'b0;
    case (sel_pc)
      SEL_PC_BRANCH: target = link + {{14{branch_imm[15]}}, branch_imm, 2'b00};
      SEL_PC_JUMP:   target = {link[31:28], jadr, 2'b00};
      SEL_PC_JR: begin
        target   = {jr_target[31:2], 2'b00};
        misalign = |jr_target[1:0];
      end
      default:       target = link;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem read at a time and
// hands {instr, instr_pc, pc_plus4} to decode over valid/ready.
module fetch_unit
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  input  logic        redirect_valid,
  input  logic [2:0]  sel_pc,
  input  logic [31:0] redirect_pc,
  input  logic [15:0] branch_imm,
  input  logic [25:0] jadr,
  input  logic [31:0] jr_target,
  output logic        misalign_err
);

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_next;
  logic [31:0]  req_addr;
  logic         discard, discard_next;
  logic         load_buf;
  logic         redirect;
  logic [31:0]  target;
  logic         misalign;

  next_pc_calc u_next_pc_calc (
    .sel_pc      (sel_pc),
    .redirect_pc (redirect_pc),
    .branch_imm  (branch_imm),
    .jadr        (jadr),
    .jr_target   (jr_target),
    .target      (target),
    .misalign    (misalign)
  );

  assign redirect = redirect_valid && is_redirect_sel(sel_pc);

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    discard_next = discard;
    load_buf     = 1'b0;
    case (state)
      IDLE: begin
        state_next = REQ;
        if (redirect) pc_next = target;
      end
      REQ: begin
        // A request already on the bus must stay stable, so its response is marked for dropping.
        if (redirect) begin
          pc_next      = target;
          discard_next = 1'b1;
        end
        if (imem_req_ready) state_next = WAIT;
      end
      WAIT: begin
        if (redirect) begin
          pc_next      = target;
          discard_next = 1'b1;
        end
        if (imem_rsp_valid) begin
          if (discard || redirect) begin
            state_next   = REQ;
            discard_next = 1'b0;
          end else begin
            load_buf   = 1'b1;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_next    = target;
          state_next = REQ;
        end else if (instr_ready) begin
          pc_next    = pc + 32'd4;
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      req_addr     <= RESET_PC;
      discard      <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      discard <= discard_next;
      if (state_next == REQ && state != REQ) req_addr <= pc_next;
      if (redirect && misalign) misalign_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr    <= 32'h0;
      instr_pc <= 32'h0;
      pc_plus4 <= 32'h0;
    end else if (load_buf) begin
      instr    <= imem_rsp_data;
      instr_pc <= req_addr;
      pc_plus4 <= req_addr + 32'd4;
    end
  end

  always_comb begin
    imem_req_valid = (state == REQ);
    imem_req_addr  = req_addr;
    instr_valid    = (state == HOLD);
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model plus scoreboards of expected
// request addresses and delivered instructions.
module tb_fetch_unit;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr, instr_pc, pc_plus4;
  logic        redirect_valid = 1'b0;
  logic [2:0]  sel_pc = 3'd0;
  logic [31:0] redirect_pc = 32'h0;
  logic [15:0] branch_imm = 16'h0;
  logic [25:0] jadr = 26'h0;
  logic [31:0] jr_target = 32'h0;
  logic        misalign_err;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk, .rst_n,
    .imem_req_valid, .imem_req_ready, .imem_req_addr,
    .imem_rsp_valid, .imem_rsp_data,
    .instr_valid, .instr_ready, .instr, .instr_pc, .pc_plus4,
    .redirect_valid, .sel_pc, .redirect_pc, .branch_imm, .jadr, .jr_target,
    .misalign_err
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_req[$];
  logic [31:0] exp_ins[$];
  int          gaps[$];
  int          take = 0;
  logic        mem_ready = 1'b0;
  int          lat = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Memory model and decode-side monitor, evaluated mid-cycle.
  initial begin : monitor
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          cnt = 0;
    int          cyc = 0;
    int          last_hs = 0;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (imem_rsp_valid) imem_rsp_valid = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(pend_addr);
          pend           = 1'b0;
        end
      end
      imem_req_ready = mem_ready;
      if (imem_req_valid && mem_ready) begin
        if (exp_req.size() == 0) check("unexpected_req", exp_req.size(), 1);
        else check("req_addr", imem_req_addr, exp_req.pop_front());
        pend      = 1'b1;
        pend_addr = imem_req_addr;
        cnt       = lat;
      end
      instr_ready = (take > 0);
      if (instr_valid && instr_ready) begin
        if (exp_ins.size() == 0) check("unexpected_instr", exp_ins.size(), 1);
        else begin
          e = exp_ins.pop_front();
          check("instr", instr, mem_word(e));
          check("instr_pc", instr_pc, e);
          check("pc_plus4", pc_plus4, e + 32'd4);
        end
        take--;
        gaps.push_back(cyc - last_hs);
        last_hs = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input logic val, input string tag);
    int n = 0;
    while (imem_req_valid !== val && n < 50) begin
      step();
      n++;
    end
    check(tag, imem_req_valid, val);
  endtask

  task automatic wait_hold(input string tag);
    int n = 0;
    while (instr_valid !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check(tag, instr_valid, 1'b1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_req.size() + exp_ins.size()) != 0 && n < 100) begin
      step();
      n++;
    end
    check(tag, exp_req.size() + exp_ins.size(), 0);
  endtask

  task automatic redirect(input logic [2:0] s, input logic [31:0] rpc, input logic [15:0] imm,
                          input logic [25:0] ja, input logic [31:0] jrt);
    redirect_valid = 1'b1;
    sel_pc         = s;
    redirect_pc    = rpc;
    branch_imm     = imm;
    jadr           = ja;
    jr_target      = jrt;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic check_held(input string tag, input logic [31:0] a);
    check({tag, "_pc"}, instr_pc, a);
    check({tag, "_instr"}, instr, mem_word(a));
    check({tag, "_plus4"}, pc_plus4, a + 32'd4);
  endtask

  initial begin
    // Reset state
    step();
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_misalign", misalign_err, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_pc_plus4", pc_plus4, 0);

    // Sequential fetch: 0,4,8 delivered, then stall holding 12
    exp_req = '{32'h0, 32'h4, 32'h8, 32'hC};
    exp_ins = '{32'h0, 32'h4, 32'h8};
    gaps.delete();
    take      = 3;
    mem_ready = 1'b1;
    lat       = 1;
    rst_n     = 1'b1;
    drain("seq_drain");
    wait_hold("seq_hold");
    check_held("seq_held", 32'hC);
    check("seq_gaps", gaps.size(), 3);
    if (gaps.size() == 3) begin
      check("seq_gap1", gaps[1], 3);
      check("seq_gap2", gaps[2], 3);
    end

    // Branch backwards and forwards from HOLD
    exp_req.push_back(32'h0000_000C);
    redirect(SEL_PC_BRANCH, 32'h10, 16'hFFFE, 26'h0, 32'h0);
    drain("br_back_drain");
    wait_hold("br_back_hold");
    check_held("br_back", 32'h0000_000C);
    exp_req.push_back(32'h0000_0020);
    redirect(SEL_PC_BRANCH, 32'h10, 16'h0003, 26'h0, 32'h0);
    drain("br_fwd_drain");
    wait_hold("br_fwd_hold");
    check_held("br_fwd", 32'h0000_0020);

    // Jump and misaligned jr
    exp_req.push_back(32'hF000_0400);
    redirect(SEL_PC_JUMP, 32'hF000_0040, 16'h0, 26'h000_0100, 32'h0);
    check("j_misalign", misalign_err, 0);
    drain("j_drain");
    wait_hold("j_hold");
    check_held("jump", 32'hF000_0400);
    exp_req.push_back(32'h0000_1000);
    redirect(SEL_PC_JR, 32'h0, 16'h0, 26'h0, 32'h0000_1003);
    check("jr_misalign", misalign_err, 1);
    drain("jr_drain");
    wait_hold("jr_hold");
    check_held("jr", 32'h0000_1000);

    // Two redirects while WAITing on a slow response: stale rsp dropped, latest target fetched
    lat = 5;
    exp_ins.push_back(32'h1000);
    exp_req.push_back(32'h1004);
    exp_req.push_back(32'h0100);
    exp_ins.push_back(32'h0100);
    exp_req.push_back(32'h0104);
    take = 1;
    wait_req(1'b1, "wait_req_up");
    wait_req(1'b0, "wait_req_acc");
    take = 1;
    redirect(SEL_PC_JUMP, 32'h0000_0100, 16'h0, 26'h000_00C0, 32'h0);
    redirect(SEL_PC_JUMP, 32'h0000_0100, 16'h0, 26'h000_0040, 32'h0);
    check("wait_no_stale", instr_valid, 0);
    lat = 1;
    drain("wait_drain");
    wait_hold("wait_hold");
    check_held("wait_held", 32'h0104);

    // Decode stall: outputs stable, no request; sel_pc 5 is not a redirect
    for (int i = 0; i < 10; i++) begin
      if (i == 3) redirect(3'd5, 32'h0, 16'h0, 26'h0, 32'h0000_2000);
      else step();
      check("stall_pc", instr_pc, 32'h0104);
      check("stall_req", imem_req_valid, 0);
    end
    check_held("stall_end", 32'h0104);

    // Redirect and instr_ready in the same HOLD cycle
    exp_ins.push_back(32'h0104);
    exp_req.push_back(32'h0244);
    take = 1;
    redirect(SEL_PC_BRANCH, 32'h0200, 16'h0010, 26'h0, 32'h0);
    drain("same_drain");
    wait_hold("same_hold");
    check_held("same", 32'h0244);

    // PC wrap through the top of the address space
    exp_req.push_back(32'hFFFF_FFFC);
    redirect(SEL_PC_JR, 32'h0, 16'h0, 26'h0, 32'hFFFF_FFFC);
    drain("wrap_jr_drain");
    wait_hold("wrap_jr_hold");
    exp_ins.push_back(32'hFFFF_FFFC);
    exp_req.push_back(32'h0);
    take = 1;
    drain("wrap_drain");
    wait_hold("wrap_hold");
    check_held("wrap", 32'h0);

    // Reset during WAIT; the late response must be ignored
    lat = 5;
    exp_ins.push_back(32'h0);
    exp_req.push_back(32'h4);
    take = 1;
    wait_req(1'b1, "rstw_req_up");
    wait_req(1'b0, "rstw_req_acc");
    mem_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("rstw_req_valid", imem_req_valid, 0);
    check("rstw_instr_valid", instr_valid, 0);
    check("rstw_misalign", misalign_err, 0);
    check("rstw_instr", instr, 0);
    check("rstw_instr_pc", instr_pc, 0);
    check("rstw_pc_plus4", pc_plus4, 0);
    exp_req.delete();
    exp_ins.delete();
    take = 0;
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("rstw_late_ignored", instr_valid, 0);
    end
    check("rstw_req_pending", imem_req_valid, 1);
    check("rstw_req_addr", imem_req_addr, 32'h0);
    lat = 1;
    exp_req.push_back(32'h0);
    mem_ready = 1'b1;
    drain("rstw_drain");
    wait_hold("rstw_hold");
    check_held("rstw_held", 32'h0);
    mem_ready = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
